// File: rtl/apb_master_bridge_pkg.sv
// Shared widths, FSM state type and watchdog sizing helper for the CPU-side APB master.
package apb_master_bridge_pkg;

  localparam int ADDR_APB        = 32;
  localparam int DATA_APB        = 32;
  localparam int APB_TIMEOUT_CYC = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // ceil(log2(timeout+1)) bits so the counter can sit at TIMEOUT without wrapping.
  function automatic int wdog_width(input int timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_master_bridge_wdog_cnt.sv
// Bus watchdog: counts ACCESS cycles, flags the last allowed one, saturates, clears on demand.
module apb_wdog_cnt
  import apb_master_bridge_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int            CW   = wdog_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (TIMEOUT != 0) && (count != MAX)) begin
      count <= count + CW'(1);
    end
  end

  // Asserted during the final permitted ACCESS cycle so the FSM can end the transfer on that edge.
  assign expire = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// CPU-side APB master: one request at a time, SETUP/ACCESS sequencing, response pulse, watchdog abort.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int ADDR_W  = ADDR_APB,
  parameter int DATA_W  = DATA_APB,
  parameter int TIMEOUT = APB_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic              cpu_rsp_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              apb_valid_cpu,
  output logic              apb_psel_cpu,
  output logic              apb_rw_cpu,
  output logic [ADDR_W-1:0] apb_addr_cpu,
  output logic              apb_enab_cpu,
  output logic [DATA_W-1:0] apb_datai_cpu,
  input  logic [DATA_W-1:0] apb_datao_cpu,
  input  logic              apb_ack_cpu
);

  apb_state_t state;
  logic       wdog_expire;

  apb_wdog_cnt #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state == ACCESS),
    .clear  (state == RESP),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cpu_ready     <= 1'b1;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_err   <= 1'b0;
      cpu_rdata     <= '0;
      apb_valid_cpu <= 1'b0;
      apb_psel_cpu  <= 1'b0;
      apb_enab_cpu  <= 1'b0;
      apb_rw_cpu    <= 1'b0;
      apb_addr_cpu  <= '0;
      apb_datai_cpu <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && cpu_ready) begin
            apb_rw_cpu    <= cpu_we;
            apb_addr_cpu  <= cpu_addr;
            apb_datai_cpu <= cpu_wdata;
            apb_valid_cpu <= 1'b1;
            apb_psel_cpu  <= 1'b1;
            cpu_ready     <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          apb_enab_cpu <= 1'b1;
          state        <= ACCESS;
        end
        ACCESS: begin
          // A real ack takes priority over a watchdog expiry landing in the same cycle.
          if (apb_ack_cpu || wdog_expire) begin
            cpu_rdata     <= (apb_ack_cpu && !apb_rw_cpu) ? apb_datao_cpu : '0;
            cpu_rsp_err   <= !apb_ack_cpu;
            cpu_rsp_valid <= 1'b1;
            apb_valid_cpu <= 1'b0;
            apb_psel_cpu  <= 1'b0;
            apb_enab_cpu  <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          cpu_rsp_valid <= 1'b0;
          cpu_ready     <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized check of apb_master_bridge against a per-transfer timing/data model.
module tb_apb_master_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_ready;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_err;
  logic [31:0] cpu_rdata;
  logic        apb_valid_cpu;
  logic        apb_psel_cpu;
  logic        apb_rw_cpu;
  logic [31:0] apb_addr_cpu;
  logic        apb_enab_cpu;
  logic [31:0] apb_datai_cpu;
  logic [31:0] apb_datao_cpu;
  logic        apb_ack_cpu;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req       (cpu_req),
    .cpu_ready     (cpu_ready),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_err   (cpu_rsp_err),
    .cpu_rdata     (cpu_rdata),
    .apb_valid_cpu (apb_valid_cpu),
    .apb_psel_cpu  (apb_psel_cpu),
    .apb_rw_cpu    (apb_rw_cpu),
    .apb_addr_cpu  (apb_addr_cpu),
    .apb_enab_cpu  (apb_enab_cpu),
    .apb_datai_cpu (apb_datai_cpu),
    .apb_datao_cpu (apb_datao_cpu),
    .apb_ack_cpu   (apb_ack_cpu)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cpu_ready, 1);
    chk({tag, "_rsp_valid"}, cpu_rsp_valid, 0);
    chk({tag, "_rsp_err"}, cpu_rsp_err, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_valid"}, apb_valid_cpu, 0);
    chk({tag, "_psel"}, apb_psel_cpu, 0);
    chk({tag, "_enab"}, apb_enab_cpu, 0);
    chk({tag, "_rw"}, apb_rw_cpu, 0);
    chk({tag, "_addr"}, apb_addr_cpu, 0);
    chk({tag, "_datai"}, apb_datai_cpu, 0);
  endtask

  // ack_cyc: ACCESS cycle (1-based) in which the slave acks; 0 or >TO means never.
  task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] datao, input int ack_cyc, input bit setup_ack);
    bit          exp_err;
    int          n_acc;
    logic [31:0] exp_rd;
    exp_err = !(ack_cyc >= 1 && ack_cyc <= TO);
    n_acc   = exp_err ? TO : ack_cyc;
    exp_rd  = (we || exp_err) ? 32'h0 : datao;

    chk("idle_ready", cpu_ready, 1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = $urandom; cpu_wdata = $urandom;
    chk("setup_psel", apb_psel_cpu, 1);
    chk("setup_enab", apb_enab_cpu, 0);
    chk("setup_valid", apb_valid_cpu, 1);
    chk("setup_ready", cpu_ready, 0);
    chk("setup_addr", apb_addr_cpu, addr);
    chk("setup_rw", apb_rw_cpu, we);
    chk("setup_datai", apb_datai_cpu, wdata);
    apb_ack_cpu = setup_ack; apb_datao_cpu = $urandom;
    for (int k = 1; k <= n_acc; k++) begin
      @(negedge clk);
      chk("access_enab", apb_enab_cpu, 1);
      chk("access_psel", apb_psel_cpu, 1);
      chk("access_addr", apb_addr_cpu, addr);
      chk("access_rw", apb_rw_cpu, we);
      chk("access_datai", apb_datai_cpu, wdata);
      chk("access_no_rsp", cpu_rsp_valid, 0);
      apb_ack_cpu   = (!exp_err && k == n_acc);
      apb_datao_cpu = (k == n_acc) ? datao : $urandom;
    end
    @(negedge clk);
    apb_ack_cpu = 1'b0;
    chk("resp_valid", cpu_rsp_valid, 1);
    chk("resp_err", cpu_rsp_err, exp_err);
    chk("resp_rdata", cpu_rdata, exp_rd);
    chk("resp_psel", apb_psel_cpu, 0);
    chk("resp_enab", apb_enab_cpu, 0);
    chk("resp_apb_valid", apb_valid_cpu, 0);
    chk("resp_ready", cpu_ready, 0);
    @(negedge clk);
    chk("post_rsp_valid", cpu_rsp_valid, 0);
    chk("post_ready", cpu_ready, 1);
    chk("post_rdata_hold", cpu_rdata, exp_rd);
    chk("post_err_hold", cpu_rsp_err, exp_err);
    chk("post_addr_hold", apb_addr_cpu, addr);
    last_rdata = exp_rd; last_err = exp_err;
    $display("xfer we=%0d addr=%h wdata=%h datao=%h ack_cyc=%0d setup_ack=%0d -> err=%0d rdata=%h",
             we, addr, wdata, datao, ack_cyc, setup_ack, exp_err, exp_rd);
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    apb_datao_cpu = '0; apb_ack_cpu = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_xfer(1'b0, 32'h4000_0010, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    do_xfer(1'b1, 32'h4000_1004, 32'h1234_5678, 32'hFFFF_FFFF, 4, 1'b0);
    do_xfer(1'b0, 32'h4000_2000, 32'h0, 32'hAAAA_5555, 0, 1'b0);
    do_xfer(1'b0, 32'h4000_3008, 32'h0, 32'hC0DE_0004, TO, 1'b1);

    // Back-to-back: request held high, slave acks continuously.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4000_0100; cpu_wdata = 32'h0;
    apb_ack_cpu = 1'b1; apb_datao_cpu = 32'h1111_2222;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) cpu_addr = 32'h4000_0200;
      chk("b2b_ready", cpu_ready, (c == 4) ? 1 : 0);
      chk("b2b_rsp_valid", cpu_rsp_valid, (c == 3) ? 1 : 0);
      chk("b2b_psel", apb_psel_cpu, (c == 1 || c == 2 || c == 5) ? 1 : 0);
      if (c == 5) begin
        cpu_req = 1'b0;
        chk("b2b_addr2", apb_addr_cpu, 32'h4000_0200);
      end
    end
    repeat (2) @(negedge clk);
    apb_ack_cpu = 1'b0;
    chk("b2b_rsp2_valid", cpu_rsp_valid, 1);
    chk("b2b_rsp2_rdata", cpu_rdata, 32'h1111_2222);
    @(negedge clk);
    chk("b2b_ready_end", cpu_ready, 1);
    $display("xfer back-to-back addr1=40000100 addr2=40000200 spacing=4");

    // Async reset in the middle of ACCESS.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h4000_0404; cpu_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pre_enab", apb_enab_cpu, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_no_rsp", cpu_rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_no_rsp", cpu_rsp_valid, 0);
    $display("xfer reset mid-ACCESS aborted");
    do_xfer(1'b0, 32'h4000_0808, 32'h0, 32'h0BAD_F00D, 2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_xfer(1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, TO + 2)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
